// File: rtl/bcam_array_if.sv
// Write, flush, search and result signals of the CAM, bundled as one port.
// The master drives writes and searches; the slave returns the match results.
interface bcam_array_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] wmask;
    logic             wvalid;
    logic             flush;
    logic             search_req;
    logic [WIDTH-1:0] search_key;
    logic [WIDTH-1:0] search_mask;
    logic             match_valid;
    logic             match_hit;
    logic             match_multi;
    logic [AW-1:0]    match_addr;
    logic [DEPTH-1:0] match_vec;

    modport master (
        output we, waddr, wdata, wmask, wvalid, flush,
        output search_req, search_key, search_mask,
        input  match_valid, match_hit, match_multi, match_addr, match_vec
    );

    modport slave (
        input  we, waddr, wdata, wmask, wvalid, flush,
        input  search_req, search_key, search_mask,
        output match_valid, match_hit, match_multi, match_addr, match_vec
    );
endinterface

// File: rtl/bcam_array.sv
// Ternary CAM: DEPTH entries of {data, don't-care mask, valid}, parallel key search.
// Latency: search 2 edges (compare, then encode); write/flush visible to the next search.
// No backpressure: one search accepted per cycle, results emerge in order.
module bcam_array #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    bcam_array_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] mask_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    logic [DEPTH-1:0] hit_vec;
    logic [DEPTH-1:0] s1_vec;
    logic             s1_vld;
    logic [AW-1:0]    lo_addr;
    logic             multi;

    // Flush is assigned last so it overrides a same-edge write's valid bit,
    // while that write's data and mask still land.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                mask_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            if (bus.we) begin
                data_q[bus.waddr]  <= bus.wdata;
                mask_q[bus.waddr]  <= bus.wmask;
                valid_q[bus.waddr] <= bus.wvalid;
            end
            if (bus.flush) begin
                valid_q <= '0;
            end
        end
    end

    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_vec[i] = valid_q[i] &
                         (&(mask_q[i] | bus.search_mask | ~(data_q[i] ^ bus.search_key)));
        end
    end

    // Stage 1 holds a zero vector when idle, so stage 2 outputs fall to 0 by construction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_vec <= '0;
        end else begin
            s1_vld <= bus.search_req;
            s1_vec <= bus.search_req ? hit_vec : '0;
        end
    end

    always_comb begin
        lo_addr = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (s1_vec[i]) begin
                lo_addr = AW'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(s1_vec & (s1_vec - DEPTH'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.match_valid <= 1'b0;
            bus.match_hit   <= 1'b0;
            bus.match_multi <= 1'b0;
            bus.match_addr  <= '0;
            bus.match_vec   <= '0;
        end else begin
            bus.match_valid <= s1_vld;
            bus.match_hit   <= |s1_vec;
            bus.match_multi <= multi;
            bus.match_addr  <= lo_addr;
            bus.match_vec   <= s1_vec;
        end
    end
endmodule

// File: tb/tb_bcam_array.sv
// Scoreboard bench for bcam_array: directed test-plan scenarios, then randomized traffic.
module tb_bcam_array;
    localparam int W  = 8;
    localparam int D  = 16;
    localparam int AW = 4;

    typedef struct packed {
        logic [D-1:0]  vec;
        logic          hit;
        logic          multi;
        logic [AW-1:0] addr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcam_array_if #(.WIDTH(W), .DEPTH(D)) bus ();

    bcam_array #(.WIDTH(W), .DEPTH(D)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    // Reference model: the table contents as seen by the next search.
    logic [W-1:0] md [D];
    logic [W-1:0] mm [D];
    logic         mv [D];
    exp_t         sb [$];
    int           nchk = 0;
    int           nerr = 0;

    task automatic model_clear();
        for (int i = 0; i < D; i++) begin
            md[i] = '0; mm[i] = '0; mv[i] = 1'b0;
        end
    endtask

    function automatic exp_t model_search(input logic [W-1:0] k, input logic [W-1:0] sm);
        exp_t e;
        int n;
        logic [W-1:0] care;
        e = '0;
        n = 0;
        for (int i = 0; i < D; i++) begin
            care = ~(mm[i] | sm);
            if (mv[i] && ((md[i] & care) == (k & care))) begin
                e.vec[i] = 1'b1;
                if (n == 0) e.addr = AW'(i);
                n++;
            end
        end
        e.hit   = (n > 0);
        e.multi = (n >= 2);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // One clock of stimulus; the expected result uses the table as it stood before this edge.
    task automatic step(input logic w, input int a, input logic [W-1:0] d, input logic [W-1:0] m,
                        input logic v, input logic fl, input logic s,
                        input logic [W-1:0] k, input logic [W-1:0] sm);
        bus.we = w; bus.waddr = AW'(a); bus.wdata = d; bus.wmask = m; bus.wvalid = v;
        bus.flush = fl; bus.search_req = s; bus.search_key = k; bus.search_mask = sm;
        if (s) sb.push_back(model_search(k, sm));
        if (w) begin md[a] = d; mm[a] = m; mv[a] = v; end
        if (fl) for (int i = 0; i < D; i++) mv[i] = 1'b0;
        @(posedge clk);
        #1;
        bus.we = 1'b0; bus.flush = 1'b0; bus.search_req = 1'b0;
    endtask

    task automatic wr(input int a, input logic [W-1:0] d, input logic [W-1:0] m, input logic v);
        step(1'b1, a, d, m, v, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic srch(input logic [W-1:0] k, input logic [W-1:0] sm);
        step(1'b0, 0, '0, '0, 1'b0, 1'b0, 1'b1, k, sm);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, {bus.match_valid, bus.match_hit, bus.match_multi, bus.match_addr, bus.match_vec}, '0);
    endtask

    // Monitor: every valid result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.match_valid) begin
            if (sb.size() == 0) begin
                nchk++; nerr++;
                $display("FAIL unexpected_result: match_valid=1 with no search outstanding");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("match_vec",   32'(bus.match_vec),   32'(e.vec));
                check("match_hit",   32'(bus.match_hit),   32'(e.hit));
                check("match_multi", 32'(bus.match_multi), 32'(e.multi));
                check("match_addr",  32'(bus.match_addr),  32'(e.addr));
            end
        end else begin
            check_outputs_zero("idle_outputs_zero");
        end
    end

    initial begin
        logic [W-1:0] d, m, k, sm;
        logic w, fl, s, v;
        int a, r;

        bus.we = 0; bus.waddr = '0; bus.wdata = '0; bus.wmask = '0; bus.wvalid = 0;
        bus.flush = 0; bus.search_req = 0; bus.search_key = '0; bus.search_mask = '0;
        model_clear();
        #2;
        check_outputs_zero("reset_outputs");
        #20 rst_n = 1'b1;                       // released mid-cycle at t=22
        @(posedge clk); #1;

        // Empty array
        srch(8'h00, 8'h00);
        idle(2);

        // Exact match
        wr(5, 8'hA5, 8'h00, 1'b1);
        srch(8'hA5, 8'h00);
        srch(8'hA4, 8'h00);

        // Ternary entry plus priority and multi-hit
        wr(3, 8'hF0, 8'h0F, 1'b1);
        wr(9, 8'hF7, 8'h00, 1'b1);
        srch(8'hF7, 8'h00);
        srch(8'hF7, 8'hFF);
        idle(2);

        // Same-edge write is invisible to the search sampled at that edge
        wr(2, 8'h11, 8'h00, 1'b1);
        step(1'b1, 2, 8'h22, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 8'h00);
        srch(8'h22, 8'h00);
        idle(2);

        // Flush beats a same-edge write; wvalid=0 invalidates
        step(1'b1, 7, 8'h55, 8'h00, 1'b1, 1'b1, 1'b0, '0, '0);
        srch(8'h55, 8'h00);
        srch(8'h00, 8'hFF);
        wr(7, 8'h55, 8'h00, 1'b0);
        srch(8'h55, 8'h00);
        idle(2);

        // Three back-to-back searches give three consecutive valid cycles
        wr(1, 8'h3C, 8'h00, 1'b1);
        wr(4, 8'h3C, 8'h01, 1'b1);
        srch(8'h3C, 8'h00);
        srch(8'h3D, 8'h00);
        check("b2b_valid_1", 32'(bus.match_valid), 32'd1);
        srch(8'h00, 8'hFF);
        check("b2b_valid_2", 32'(bus.match_valid), 32'd1);
        idle(1);
        check("b2b_valid_3", 32'(bus.match_valid), 32'd1);
        idle(2);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            r  = $urandom_range(0, 9);
            w  = (r < 4);
            fl = (r == 4) && ($urandom_range(0, 3) == 0);
            s  = ($urandom_range(0, 2) != 0);
            a  = $urandom_range(0, D - 1);
            d  = 8'($urandom);
            m  = 8'($urandom) & 8'($urandom) & 8'($urandom);
            v  = ($urandom_range(0, 4) != 0);
            k  = md[$urandom_range(0, D - 1)];
            if ($urandom_range(0, 3) == 0) k = k ^ 8'(1 << $urandom_range(0, 7));
            sm = 8'($urandom) & 8'($urandom) & 8'($urandom);
            step(w, a, d, m, v, fl, s, k, sm);
        end
        idle(3);

        // Async reset with a search in flight: outputs clear at once, nothing stale follows
        wr(6, 8'h66, 8'h00, 1'b1);
        srch(8'h66, 8'h00);
        #2;
        rst_n = 1'b0;
        sb.delete();
        model_clear();
        #1;
        check_outputs_zero("async_reset_outputs");
        @(posedge clk); #1;
        check_outputs_zero("held_reset_outputs");
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        idle(4);
        srch(8'h66, 8'h00);
        srch(8'h00, 8'h00);
        idle(4);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/bcam_array.md
# bcam_array

Parametrised binary/ternary content-addressable memory of DEPTH entries by WIDTH bits. Each entry holds a data word, a per-bit don't-care mask and a valid flag. A two-stage pipelined search compares a key against all entries in parallel and returns a registered match vector, the lowest matching index and a multi-hit flag. This is the lookup block for the lab's tag/lookup datapath and the multi-entry successor to the single-bit CAM cell.

## Interface
- WIDTH, 8, bits per entry and per search key (≥1)
- DEPTH, 16, number of entries (≥2, power of two)
- AW, $clog2(DEPTH), derived localparam, address width (not overridable)

- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- we  in  1  write enable
- waddr  in  AW  entry written
- wdata  in  WIDTH  data stored
- wmask  in  WIDTH  per-bit don't-care stored with entry (1 = ignore bit)
- wvalid  in  1  valid flag written (0 = invalidate entry)
- flush  in  1  clear valid flag of every entry
- search_req  in  1  start a search this cycle
- search_key  in  WIDTH  key compared
- search_mask  in  WIDTH  per-search don't-care (1 = ignore bit)
- match_valid  out  1  result outputs are valid this cycle
- match_hit  out  1  at least one entry matched
- match_multi  out  1  two or more entries matched
- match_addr  out  AW  lowest matching index; 0 when no hit
- match_vec  out  DEPTH  per-entry match bits

## Operation
- Entry i matches when valid[i] = 1 and, for every bit b, wmask_i[b] | search_mask[b] | (data_i[b] == search_key[b]).
- Write: when we = 1 at an edge, entry waddr ← {wdata, wmask, wvalid}. Other entries are unchanged.
- Flush: when flush = 1 at an edge, all valid flags are cleared. Data and masks are retained. If flush and we occur at the same edge, flush wins for every entry including waddr. Data and mask at waddr are still written, but valid = 0.
- Search stage 1 (edge k, search_req = 1): compare the key against the array contents as they stood before edge k, and register match_vec_s1 and a valid flag. A write or flush at the same edge k is not visible to this search. It is visible to a search sampled at edge k+1.
- Search stage 2 (edge k+1): from match_vec_s1, register match_vec, match_hit = OR of the vector, match_addr = lowest set index, match_multi = popcount ≥ 2, and match_valid = stage-1 valid.
- No backpressure. One search can be accepted per cycle, and back-to-back searches produce back-to-back results in order.
- When match_valid = 0, match_hit, match_multi, match_addr and match_vec are driven to 0.
- An all-ones search_mask matches every valid entry.

## Timing
- Search latency is 2 edges. A request sampled at edge k gives results visible after edge k+1, and they hold for one cycle.
- Write and flush latency is 1 edge. A search sampled at the following edge sees the new contents.
- rst_n low forces the following immediately, without waiting for clk:
  - all valid flags 0, data 0, masks 0;
  - both pipeline stages cleared;
  - all outputs 0 (match_valid, match_hit, match_multi, match_addr, match_vec).
- Reset mid-search discards in-flight results, so no match_valid pulse follows the release of reset.
- Deassertion of reset is synchronised externally. The first edge after release may accept write or search.

## Test plan
- **Reset and empty array:** release reset, then search key 0x00 with search_mask 0x00 → match_valid = 1 two edges later, match_hit = 0, match_addr = 0, match_vec = 0.
- **Exact match:** write entry 5 = 0xA5 with mask 0x00 and valid 1. Search 0xA5 → hit = 1, addr = 5, vec = 0x0020, multi = 0. Search 0xA4 → hit = 0.
- **Ternary and priority:**
  - write entry 3 = 0xF0 with mask 0x0F, and entry 9 = 0xF7 with mask 0x00;
  - search 0xF7 → vec has bits 3 and 9 set, addr = 3, multi = 1;
  - search 0xF7 with search_mask 0xFF → every valid entry matches.
- **Same-edge write/search:** entry 2 holds 0x11. At one edge, write entry 2 = 0x22 and search 0x22 → no hit. Search 0x22 at the next edge → hit at addr 2.
- **Flush and invalidate:**
  - flush together with a write to entry 7 → all subsequent searches miss, including entry 7;
  - rewrite entry 7 with wvalid = 0 → still misses.
- **Pipelining and async reset:** issue 3 back-to-back searches → 3 consecutive match_valid cycles with results in order. Assert rst_n low between clock edges with one search in flight → outputs drop to 0 at once and no stale result appears after release.
